mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Multi-channel byte-serial memory arbiter.
// Grants one requester at a time and walks its access a byte per cycle.
module mem_arbiter #(
  parameter int NUM_CH = 3,
  parameter int RR_EN  = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  io_buffer_full,
  input  logic                  flush,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [31:0]           mem_a,
  output logic                  mem_wr,
  input  logic [NUM_CH-1:0]     ch_req,
  input  logic [32*NUM_CH-1:0]  ch_addr,
  input  logic [2*NUM_CH-1:0]   ch_size,
  input  logic [NUM_CH-1:0]     ch_wr,
  input  logic [NUM_CH-1:0]     ch_sign,
  input  logic [32*NUM_CH-1:0]  ch_wdata,
  output logic [NUM_CH-1:0]     ch_rdy,
  output logic [31:0]           rdata,
  output logic [2:0]            grant_id
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    COOLDOWN
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        cnt;
  logic [2:0]        last_grant;
  logic [1:0]        l_size;
  logic              l_wr;
  logic              l_sign;
  logic [31:0]       l_wdata;
  logic [31:0]       rbuf;
  logic [NUM_CH-1:0] rdy_r;

  logic [31:0] addr_a [8];
  logic [31:0] wdat_a [8];
  logic [1:0]  size_a [8];
  logic [7:0]  req_a;
  logic [7:0]  wr_a;
  logic [7:0]  sign_a;

  logic        en;
  logic        fl;
  logic        found;
  logic [2:0]  gnt;
  logic [3:0]  j;
  logic        do_grant;
  logic        abort;
  logic        done;
  logic [2:0]  nb;
  logic [2:0]  nxt;
  logic [1:0]  bidx;
  logic [7:0]  wbyte;
  logic [31:0] rmerge;
  logic [31:0] rfill;
  logic [NUM_CH-1:0] gnt_oh;

  function automatic logic [2:0] nbytes(input logic [1:0] s);
    return s[1] ? 3'd4 : (s[0] ? 3'd2 : 3'd1);
  endfunction

  // Flatten channel buses into fixed 8-entry tables
  always_comb begin
    addr_a = '{default: '0};
    wdat_a = '{default: '0};
    size_a = '{default: '0};
    req_a  = '0;
    wr_a   = '0;
    sign_a = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      addr_a[i] = ch_addr[32*i +: 32];
      wdat_a[i] = ch_wdata[32*i +: 32];
      size_a[i] = ch_size[2*i +: 2];
      req_a[i]  = ch_req[i];
      wr_a[i]   = ch_wr[i];
      sign_a[i] = ch_sign[i];
    end
  end

  always_comb begin
    found = 1'b0;
    gnt   = '0;
    j     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (RR_EN != 0)
        j = 4'(last_grant) + 4'd1 + 4'(i);
      else
        j = 4'(i);
      if (j >= 4'(NUM_CH))
        j = j - 4'(NUM_CH);
      if (!found && req_a[j[2:0]]) begin
        found = 1'b1;
        gnt   = j[2:0];
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < NUM_CH; i++)
      gnt_oh[i] = (grant_id == 3'(i));
  end

  assign en    = rdy_in & ~io_buffer_full;
  assign fl    = flush & rdy_in;
  assign nb    = nbytes(l_size);
  assign nxt   = cnt + 3'd1;
  assign bidx  = 2'(cnt - 3'd1);
  assign wbyte = 8'(l_wdata >> {nxt[1:0], 3'b000});

  assign do_grant = (state_q == IDLE) & en & ~fl & found;
  // Stores are never torn: only reads are abortable
  assign abort = fl & ~l_wr &
                 ((state_q == ACCESS) | (state_q == COOLDOWN));
  assign done = (state_q == ACCESS) & en &
                (l_wr ? (cnt == nb - 3'd1) : (cnt == nb));

  always_comb begin
    rmerge = rbuf;
    rmerge[{bidx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    rfill = rmerge;
    unique case (1'b1)
      l_size == 2'b00:
        rfill = {{24{l_sign & rmerge[7]}}, rmerge[7:0]};
      l_size == 2'b01:
        rfill = {{16{l_sign & rmerge[15]}}, rmerge[15:0]};
      default:
        rfill = rmerge;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (do_grant)
          state_d = ACCESS;
      ACCESS:
        if (abort)
          state_d = IDLE;
        else if (done)
          state_d = COOLDOWN;
      COOLDOWN:
        if (abort | en)
          state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt        <= '0;
      mem_a      <= '0;
      mem_dout   <= '0;
      mem_wr     <= 1'b0;
      rdy_r      <= '0;
      rdata      <= '0;
      grant_id   <= '0;
      last_grant <= 3'(NUM_CH - 1);
      l_size     <= '0;
      l_wr       <= 1'b0;
      l_sign     <= 1'b0;
      l_wdata    <= '0;
      rbuf       <= '0;
    end else if (abort) begin
      cnt    <= '0;
      mem_wr <= 1'b0;
      rdy_r  <= '0;
    end else if (en) begin
      unique case (state_q)
        IDLE: begin
          if (do_grant) begin
            l_size     <= size_a[gnt];
            l_wr       <= wr_a[gnt];
            l_sign     <= sign_a[gnt];
            l_wdata    <= wdat_a[gnt];
            mem_a      <= addr_a[gnt];
            mem_wr     <= wr_a[gnt];
            mem_dout   <= wdat_a[gnt][7:0];
            cnt        <= '0;
            grant_id   <= gnt;
            last_grant <= gnt;
            rbuf       <= '0;
          end
        end
        ACCESS: begin
          cnt <= nxt;
          if (nxt < nb) begin
            mem_a <= mem_a + 32'd1;
            if (l_wr)
              mem_dout <= wbyte;
          end
          // Read data trails the address by one cycle
          if (!l_wr && cnt != 3'd0)
            rbuf <= rmerge;
          if (done) begin
            mem_wr <= 1'b0;
            rdy_r  <= gnt_oh;
            if (!l_wr)
              rdata <= rfill;
          end
        end
        COOLDOWN:
          rdy_r <= '0;
        default: ;
      endcase
    end
  end

  assign ch_rdy = abort ? '0 : rdy_r;

endmodule
